// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the memory-stage SRAM/UART responder.
package sram_responder_pkg;

  typedef enum logic [3:0] {
    IDLE, RD1, RD2, WR1, WR2, WR3, URD1, URD2, UWR1, UWR2, DONE
  } state_e;

  localparam logic [1:0]  RAM_BANK       = 2'b00;
  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
  localparam logic [15:0] BUS_Z          = 16'hZZZZ;
  localparam int          CNT_W          = 3;

endpackage

// File: rtl/sram_responder_bus_tristate.sv
// Tristate driver for the shared RAM1/UART data bus; also returns the sampled bus value.
module bus_tristate
  import sram_responder_pkg::*;
(
  input  logic        oe,
  input  logic [15:0] dout,
  inout  wire  [15:0] pad,
  output logic [15:0] din
);

  assign pad = oe ? dout : BUS_Z;
  assign din = pad;

endmodule

// File: rtl/sram_responder.sv
// Memory-stage responder: sequences SRAM and UART accesses on the shared bus and
// freezes the pipeline via stall until each access reaches DONE.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int WE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Address,
  input  logic [15:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [15:0] ReadData,
  output logic        stall,
  output logic [17:0] ram_addr,
  inout  wire  [15:0] ram_data,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);

  localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] we_cnt_q, we_cnt_d;
  logic [15:0]      read_data_q, read_data_d;
  logic             bus_oe;
  logic [15:0]      bus_in;
  logic             req;

  assign req      = MemRead | MemWrite;
  assign ram_addr = {RAM_BANK, Address};
  assign ReadData = read_data_q;

  bus_tristate u_bus (
    .oe   (bus_oe),
    .dout (WriteData),
    .pad  (ram_data),
    .din  (bus_in)
  );

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    state_d     = state_q;
    we_cnt_d    = we_cnt_q;
    read_data_d = read_data_q;
    stall       = 1'b1;
    bus_oe      = 1'b0;
    ram_en_n    = 1'b1;
    ram_oe_n    = 1'b1;
    ram_we_n    = 1'b1;
    uart_rdn    = 1'b1;
    uart_wrn    = 1'b1;
    case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          if (MemWrite) begin
            if (Address == UART_DATA_ADDR)      state_d = UWR1;
            else if (Address == UART_STAT_ADDR) state_d = DONE;
            else                                state_d = WR1;
          end else begin
            if (Address == UART_DATA_ADDR) state_d = URD1;
            else if (Address == UART_STAT_ADDR) begin
              read_data_d = {14'b0, data_ready, tbre & tsre};
              state_d     = DONE;
            end else state_d = RD1;
          end
        end
      end
      RD1: begin
        ram_en_n = 1'b0;
        ram_oe_n = 1'b0;
        state_d  = RD2;
      end
      RD2: begin
        ram_en_n    = 1'b0;
        ram_oe_n    = 1'b0;
        read_data_d = bus_in;
        state_d     = DONE;
      end
      WR1: begin
        ram_en_n = 1'b0;
        bus_oe   = 1'b1;
        state_d  = WR2;
      end
      WR2: begin
        ram_en_n = 1'b0;
        bus_oe   = 1'b1;
        ram_we_n = 1'b0;
        if (we_cnt_q == WE_LAST) begin
          we_cnt_d = '0;
          state_d  = WR3;
        end else we_cnt_d = we_cnt_q + 1'b1;
      end
      WR3: begin
        ram_en_n = 1'b0;
        bus_oe   = 1'b1;
        state_d  = DONE;
      end
      URD1: begin
        uart_rdn = 1'b0;
        state_d  = URD2;
      end
      URD2: begin
        uart_rdn    = 1'b0;
        read_data_d = {8'h00, bus_in[7:0]};
        state_d     = DONE;
      end
      UWR1: begin
        bus_oe  = 1'b1;
        state_d = UWR2;
      end
      UWR2: begin
        bus_oe   = 1'b1;
        uart_wrn = 1'b0;
        if (we_cnt_q == WE_LAST) begin
          we_cnt_d = '0;
          state_d  = DONE;
        end else we_cnt_d = we_cnt_q + 1'b1;
      end
      DONE: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_cnt_q    <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      we_cnt_q    <= we_cnt_d;
      read_data_q <= read_data_d;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench for sram_responder against a transaction-level memory/UART model.
module tb_sram_responder;
  import sram_responder_pkg::*;

  localparam int WE = 2;

  logic        clk = 1'b0, rst = 1'b0;
  logic [15:0] Address = '0, WriteData = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic        data_ready = 1'b0, tbre = 1'b0, tsre = 1'b0;
  wire  [15:0] ReadData, ram_data;
  wire  [17:0] ram_addr;
  wire         stall, ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;

  sram_responder #(.WE_CYCLES(WE)) dut (
    .clk(clk), .rst(rst), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .stall(stall),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_en_n(ram_en_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .uart_rdn(uart_rdn),
    .uart_wrn(uart_wrn), .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  always #5 clk = ~clk;

  // Bus-side devices: SRAM chip and UART data register.
  logic [15:0] sram [0:255];
  logic [7:0]  uart_byte = 8'h00;
  logic [15:0] uart_tx = 16'h0000;
  wire         sram_drv = !ram_en_n && !ram_oe_n && ram_we_n;
  assign ram_data = !uart_rdn ? {8'h5A, uart_byte} :
                    (sram_drv ? sram[ram_addr[7:0]] : 16'hzzzz);
  always @(posedge clk) begin
    if (!ram_en_n && !ram_we_n) sram[ram_addr[7:0]] <= ram_data;
    if (!uart_wrn) uart_tx <= ram_data;
  end

  // Reference: what the pipeline has stored, and what ReadData should hold.
  logic [15:0] ref_mem [0:255];
  logic [15:0] exp_rd = 16'h0000;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata);
    int  n_stall = 0, n_oe = 0, n_we = 0, n_rdn = 0, n_wrn = 0, n_en = 0;
    int  n_bus = 0, bad_bus = 0;
    int  e_stall, e_oe = 0, e_we = 0, e_rdn = 0, e_wrn = 0, e_en = 0, e_bus = -1;
    bit  done = 0;
    bit  is_uart = (addr == UART_DATA_ADDR);
    bit  is_stat = (addr == UART_STAT_ADDR);
    if (wr) begin
      if (is_uart)      begin e_stall = 2 + WE; e_wrn = WE; e_bus = WE + 1; end
      else if (is_stat) e_stall = 1;
      else begin e_stall = 3 + WE; e_we = WE; e_en = WE + 2; e_bus = WE + 2; end
    end else begin
      if (is_uart)      begin e_stall = 3; e_rdn = 2; end
      else if (is_stat) e_stall = 1;
      else begin e_stall = 3; e_oe = 2; e_en = 2; end
    end
    @(posedge clk); #1;
    Address = addr; WriteData = wdata; MemRead = rd; MemWrite = wr;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("ram_addr", ram_addr, {2'b00, addr});
      if (!ram_oe_n) n_oe++;
      if (!ram_we_n) n_we++;
      if (!ram_en_n) n_en++;
      if (!uart_rdn) n_rdn++;
      if (!uart_wrn) n_wrn++;
      if ((!ram_we_n || !uart_wrn) && ram_data !== wdata) bad_bus++;
      if (ram_data === wdata) n_bus++;
      if (stall) n_stall++;
      else done = 1;
    end
    chk("done_reached", done, 1);
    if (wr) begin
      if (is_uart) chk("uart_tx", uart_tx, wdata);
      else if (!is_stat) ref_mem[addr[7:0]] = wdata;
    end else begin
      if (is_uart)      exp_rd = {8'h00, uart_byte};
      else if (is_stat) exp_rd = {14'b0, data_ready, tbre & tsre};
      else              exp_rd = ref_mem[addr[7:0]];
    end
    chk("read_data", ReadData, exp_rd);
    chk("stall_cycles", n_stall, e_stall);
    chk("oe_cycles", n_oe, e_oe);
    chk("we_cycles", n_we, e_we);
    chk("en_cycles", n_en, e_en);
    chk("rdn_cycles", n_rdn, e_rdn);
    chk("wrn_cycles", n_wrn, e_wrn);
    chk("bus_during_strobe", bad_bus, 0);
    if (e_bus >= 0) chk("bus_drive_cycles", n_bus, e_bus);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'($urandom);
      sram[i]    = ref_mem[i];
    end
    ref_mem[8'h40] = 16'h1234;
    sram[8'h40]    = 16'h1234;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_read_data", ReadData, 16'h0000);
    chk("reset_stall", stall, 1'b0);
    chk("reset_strobes", {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'h1F);
    rst = 1'b1;

    access(1, 0, 16'h0040, 16'h0000);
    access(0, 1, 16'h0041, 16'hBEEF);
    access(1, 0, 16'h0041, 16'h0000);
    data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
    access(1, 0, UART_STAT_ADDR, 16'h0000);
    uart_byte = 8'hA5;
    access(1, 0, UART_DATA_ADDR, 16'h0000);
    access(0, 1, UART_DATA_ADDR, 16'h0041);
    access(1, 1, 16'h0010, 16'h7777);
    access(1, 0, 16'h0010, 16'h0000);

    // Reset in the middle of a write pulse.
    @(posedge clk); #1;
    Address = 16'h00F0; WriteData = 16'hCAFE; MemWrite = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (!ram_we_n) seen = 1;
    end
    chk("we_pulse_seen", seen, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_we_n", ram_we_n, 1'b1);
    chk("rst_en_n", ram_en_n, 1'b1);
    chk("rst_read_data", ReadData, 16'h0000);
    MemWrite = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", stall, 1'b0);
    chk("post_rst_read_data", ReadData, 16'h0000);
    exp_rd = 16'h0000;

    for (int t = 0; t < 40; t++) begin
      logic [15:0] a, w;
      a = 16'($urandom_range(0, 127));
      w = 16'($urandom) | 16'h0001;
      case ($urandom_range(0, 6))
        0: access(1, 0, a, w);
        1: access(0, 1, a, w);
        2: access(1, 1, a, w);
        3: begin uart_byte = 8'($urandom); access(1, 0, UART_DATA_ADDR, w); end
        4: access(0, 1, UART_DATA_ADDR, w);
        5: begin
          data_ready = 1'($urandom); tbre = 1'($urandom); tsre = 1'($urandom);
          access(1, 0, UART_STAT_ADDR, w);
        end
        default: access(0, 1, UART_STAT_ADDR, w);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Responder end of the memory-stage interface. Accepts the pipeline's MemRead/MemWrite requests (the same request lines the fake data memory serves today), sequences the shared RAM1/UART data bus, and returns ReadData with a stall signal that freezes the pipeline until the access completes. It replaces the fake data memory behind exe_mem and mem_wb.

## Interface
- RAM_BANK, 2'b00, upper bits of the 18-bit ram_addr
- UART_DATA_ADDR, 16'hBF00, UART data register address
- UART_STAT_ADDR, 16'hBF01, UART status register address
- WE_CYCLES, 1, width of the active-low pulses on ram_we_n and uart_wrn (1..4)

- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- Address  in  16  request address from exe_mem
- WriteData  in  16  store data
- MemRead  in  1  read request, held until stall falls
- MemWrite  in  1  write request, held until stall falls
- ReadData  out  16  registered read result
- stall  out  1  combinational freeze request to the pipeline
- ram_addr  out  18  {RAM_BANK, Address}
- ram_data  inout  16  shared RAM1/UART bus
- ram_en_n, ram_oe_n, ram_we_n  out  1 each  SRAM controls
- uart_rdn, uart_wrn  out  1 each  UART strobes
- data_ready, tbre, tsre  in  1 each  UART status

## Operation
- States: IDLE, RD1, RD2, WR1, WR2, WR3, URD1, URD2, UWR1, UWR2, DONE.
- Request: req = MemRead | MemWrite. If both are high, the block does a write.
- IDLE and req, with a write to UART_DATA_ADDR: go to UWR1. A read of UART_DATA_ADDR goes to URD1. A read of UART_STAT_ADDR latches ReadData = {14'b0, data_ready, tbre & tsre} and goes to DONE. A write to UART_STAT_ADDR is ignored and goes to DONE. Other reads go to RD1, other writes to WR1.
- RD1: ram_en_n = 0, ram_oe_n = 0, bus released.
- RD2: same controls; ReadData <= ram_data at the exit edge.
- WR1: ram_en_n = 0, bus driven with WriteData, ram_we_n = 1.
- WR2: ram_we_n = 0 for WE_CYCLES cycles, using an internal counter.
- WR3: ram_we_n = 1, bus still driven.
- URD1 and URD2: ram_en_n = 1, uart_rdn = 0; ReadData <= {8'h00, ram_data[7:0]} at the URD2 exit edge.
- UWR1: bus driven, uart_wrn = 1.
- UWR2: uart_wrn = 0 for WE_CYCLES cycles.
- All of UWR1/UWR2 run with ram_en_n = 1.
- DONE: every strobe is inactive and the bus is released. Returns to IDLE unconditionally; a request is never accepted in DONE.
- stall = (IDLE & req) | (state ∉ {IDLE, DONE}).
- The bus is driven only in WR1–WR3 and UWR1–UWR2. Otherwise it is high-Z.
- Outputs in IDLE: every strobe high, ram_oe_n = 1.

## Timing
- Reset (async, any state): state goes to IDLE, ReadData = 0, ram_en_n/oe_n/we_n = 1, uart_rdn/wrn = 1, bus high-Z, WE counter = 0. Reset mid-write ends the we pulse immediately.
- Request accepted at edge k: SRAM read has ReadData valid and stall = 0 in cycle k+3 (DONE).
- SRAM write: DONE in cycle k+3+WE_CYCLES.
- UART read: DONE in cycle k+3. UART write: DONE in cycle k+2+WE_CYCLES.
- Status read: DONE in cycle k+1.
- ram_addr is combinational from Address, which is stable while stall = 1.
- ReadData holds its value until the next read completes. Writes leave it unchanged.
- The pipeline advances on the DONE edge. A new request seen in the following IDLE cycle is accepted normally; back-to-back accesses have a one-cycle gap.
- ram_data is driven in the cycle before ram_we_n falls and held for one cycle after it rises.

## Structure
- Shared package: state encoding, UART address constants, and the bus-release value 16'hZZZZ.
- One sub-module, bus_tristate: drives ram_data when enabled, otherwise high-Z, and exposes the sampled input value.

## Test plan
- SRAM model preloaded with 0x1234 at 0x0040. MemRead at 0x0040 → stall high for 3 cycles, ReadData = 0x1234 in DONE, ram_oe_n low exactly in RD1–RD2.
- MemWrite 0xBEEF to 0x0041, WE_CYCLES = 2 → ram_we_n low for 2 cycles, bus = 0xBEEF from WR1 through WR3. A subsequent read returns 0xBEEF.
- Read of 0xBF01 with data_ready = 1, tbre = 1, tsre = 0 → ReadData = 0x0002, stall for 1 cycle, no strobe asserted.
- UART data byte 0xA5 on bus, read of 0xBF00 → uart_rdn low for 2 cycles, ram_en_n high, ReadData = 0x00A5. Write of 0x0041 → uart_wrn pulse with bus = 0x0041.
- rst asserted during WR2 → ram_we_n = 1 and bus high-Z in the same cycle, ReadData = 0, stall = 0 after release with no request.
- MemRead and MemWrite both high at 0x0010 → a write is performed; ReadData is unchanged.
